// File: rtl/step_run_ctrl_if.sv
// Control/status bundle between the button front end and the run/step controller.
interface step_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             step_in;
  logic             run_in;
  logic             halt;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;

  // Driver of the debounced buttons and halt flag; observer of the controller.
  modport master (
    output step_in, run_in, halt,
    input  cpu_en, running, halted, cycle_cnt
  );

  // The controller itself.
  modport slave (
    input  step_in, run_in, halt,
    output cpu_en, running, halted, cycle_cnt
  );
endinterface

// File: rtl/step_run_ctrl.sv
// Run/single-step controller: synchronizes the debounced step and run buttons,
// sequences IDLE/STEP/RUN/HALT, gates the core clock-enable and counts the
// cycles the core actually executed.
module step_run_ctrl #(
  parameter int RUN_DIV = 1,
  parameter int CNT_W   = 32
) (
  input logic            clk,
  input logic            rst,
  step_run_ctrl_if.slave bus
);

  localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             s1, s2, s3;
  logic             r1, r2;
  logic [1:0]       warm;
  logic             step_edge;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;
  logic             cpu_en;
  logic             running;
  logic             halted;

  // Input synchronizers and the step edge-detect history flop.
  // The first two edges after reset only fill the s1/s2 chain, so s3 is held
  // at 1 and then loaded from s1; a level already high across reset release
  // therefore never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked state update uses <= so all flops sample the
    // pre-edge values; a blocking = here would let s2 see the new s1.
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b1;
      r1   <= 1'b0;
      r2   <= 1'b0;
      warm <= 2'b00;
    end else begin
      s1   <= bus.step_in;
      s2   <= s1;
      r1   <= bus.run_in;
      r2   <= r1;
      warm <= {warm[0], 1'b1};
      if (warm[1]) begin
        s3 <= s2;
      end else if (warm[0]) begin
        s3 <= s1;
      end
    end
  end

  assign step_edge = s2 & ~s3;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: halt outranks run request/deassert, which outranks step.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred when a branch below leaves next_state alone.
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.halt) begin
          next_state = HALT;
        end else if (r2) begin
          next_state = RUN;
        end else if (step_edge) begin
          next_state = STEP;
        end
      end
      STEP: next_state = IDLE;
      RUN: begin
        if (bus.halt) begin
          next_state = HALT;
        end else if (!r2) begin
          next_state = IDLE;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; halt masks the enable in the very cycle it is raised.
  always_comb begin
    running = (state == RUN);
    halted  = (state == HALT);
    cpu_en  = 1'b0;
    if (!bus.halt) begin
      if (state == STEP) begin
        cpu_en = 1'b1;
      end else if ((state == RUN) && (div_cnt == DIV_LAST)) begin
        cpu_en = 1'b1;
      end
    end
  end

  // Run divider: counts only while staying in RUN, so it is zero on entry
  // and cleared again whenever RUN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if ((state == RUN) && (next_state == RUN)) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  // Executed-cycle counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cpu_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.running   = running;
  assign bus.halted    = halted;
  assign bus.cycle_cnt = cnt;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Self-checking bench for step_run_ctrl. Two instances: dut_a (RUN_DIV=1,
// CNT_W=4) and dut_b (RUN_DIV=4, CNT_W=32). Expected cpu_en pulses (cycle
// number and cycle_cnt value during the pulse) are queued when stimulus is
// applied and matched against pulses recorded at each falling clock edge.
module tb_step_run_ctrl;

  typedef struct packed {
    int cyc;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int checks   = 0;
  int failures = 0;

  ev_t exp_a[$];
  ev_t exp_b[$];
  ev_t obs_a[256];
  ev_t obs_b[256];
  int  obs_a_wr = 0;
  int  obs_b_wr = 0;
  int  obs_a_rd = 0;
  int  obs_b_rd = 0;
  int  cnt_a    = 0;
  int  cnt_b    = 0;

  step_run_ctrl_if #(.CNT_W(4))  if_a ();
  step_run_ctrl_if #(.CNT_W(32)) if_b ();

  step_run_ctrl #(.RUN_DIV(1), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  step_run_ctrl #(.RUN_DIV(4), .CNT_W(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  // Cycle index: the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every enabled cycle of both instances, mid-cycle.
  always @(negedge clk) begin
    if (if_a.cpu_en === 1'b1) begin
      obs_a[obs_a_wr % 256] = ev_t'{cyc: cyc, cnt: int'(if_a.cycle_cnt)};
      obs_a_wr++;
    end
    if (if_b.cpu_en === 1'b1) begin
      obs_b[obs_b_wr % 256] = ev_t'{cyc: cyc, cnt: int'(if_b.cycle_cnt)};
      obs_b_wr++;
    end
  end

  function automatic ev_t mk_ev(input int c, input int n);
    return ev_t'{cyc: c, cnt: n};
  endfunction

  // Advance n cycles; returns 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  // Scoreboard: pop every expected pulse and compare with the recorded ones.
  task automatic sb_drain(input bit on_b, input string name);
    ev_t e;
    ev_t o;
    int  wr;
    int  rd;
    while ((on_b ? exp_b.size() : exp_a.size()) > 0) begin
      if (on_b) e = exp_b.pop_front();
      else      e = exp_a.pop_front();
      wr = on_b ? obs_b_wr : obs_a_wr;
      rd = on_b ? obs_b_rd : obs_a_rd;
      checks++;
      if (rd >= wr) begin
        failures++;
        $display("FAIL %s: no cpu_en pulse seen, required cycle %0d cnt %0d", name, e.cyc, e.cnt);
      end else begin
        if (on_b) begin
          o = obs_b[obs_b_rd % 256];
          obs_b_rd++;
        end else begin
          o = obs_a[obs_a_rd % 256];
          obs_a_rd++;
        end
        if (o.cyc !== e.cyc || o.cnt !== e.cnt) begin
          failures++;
          $display("FAIL %s: pulse at cycle %0d cnt %0d, required cycle %0d cnt %0d",
                   name, o.cyc, o.cnt, e.cyc, e.cnt);
        end
      end
    end
    wr = on_b ? obs_b_wr : obs_a_wr;
    rd = on_b ? obs_b_rd : obs_a_rd;
    checks++;
    if (rd != wr) begin
      failures++;
      $display("FAIL %s: %0d unexpected cpu_en pulse(s), required 0", name, wr - rd);
    end
    if (on_b) obs_b_rd = obs_b_wr;
    else      obs_a_rd = obs_a_wr;
  endtask

  task automatic test_reset();
    if_a.step_in = 1'b0; if_a.run_in = 1'b0; if_a.halt = 1'b0;
    if_b.step_in = 1'b0; if_b.run_in = 1'b0; if_b.halt = 1'b0;
    tick(3);
    checks++;
    if (if_a.cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en_a: got %b, required 0", if_a.cpu_en); end
    checks++;
    if (if_a.running !== 1'b0) begin failures++; $display("FAIL reset_running_a: got %b, required 0", if_a.running); end
    checks++;
    if (if_a.halted !== 1'b0) begin failures++; $display("FAIL reset_halted_a: got %b, required 0", if_a.halted); end
    checks++;
    if (if_a.cycle_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt_a: got %0d, required 0", if_a.cycle_cnt); end
    checks++;
    if (if_b.cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en_b: got %b, required 0", if_b.cpu_en); end
    checks++;
    if (if_b.running !== 1'b0) begin failures++; $display("FAIL reset_running_b: got %b, required 0", if_b.running); end
    checks++;
    if (if_b.halted !== 1'b0) begin failures++; $display("FAIL reset_halted_b: got %b, required 0", if_b.halted); end
    checks++;
    if (if_b.cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt_b: got %0d, required 0", if_b.cycle_cnt); end
    rst = 1'b0;
    tick(8);
    sb_drain(1'b0, "reset_idle_a");
    sb_drain(1'b1, "reset_idle_b");
  endtask

  task automatic test_step();
    int c;
    tick(1);
    c = cyc;
    if_a.step_in = 1'b1;
    exp_a.push_back(mk_ev(c + 3, cnt_a % 16));
    cnt_a++;
    tick(20);
    if_a.step_in = 1'b0;
    tick(4);
    checks++;
    if (if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL step_cnt: got %0d, required %0d", if_a.cycle_cnt, cnt_a % 16);
    end
    checks++;
    if (if_a.running !== 1'b0 || if_a.halted !== 1'b0) begin
      failures++; $display("FAIL step_idle: running=%b halted=%b, required 0/0", if_a.running, if_a.halted);
    end
    sb_drain(1'b0, "step_single");
  endtask

  task automatic test_step_held_reset();
    int c;
    tick(1);
    rst          = 1'b1;
    if_a.step_in = 1'b1;
    cnt_a        = 0;
    cnt_b        = 0;
    tick(3);
    rst = 1'b0;
    tick(12);
    checks++;
    if (if_a.cycle_cnt !== 4'd0) begin
      failures++; $display("FAIL held_reset_cnt: got %0d, required 0", if_a.cycle_cnt);
    end
    sb_drain(1'b0, "held_reset_no_step");
    if_a.step_in = 1'b0;
    tick(4);
    c = cyc;
    if_a.step_in = 1'b1;
    exp_a.push_back(mk_ev(c + 3, cnt_a % 16));
    cnt_a++;
    tick(6);
    if_a.step_in = 1'b0;
    tick(3);
    checks++;
    if (if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL held_reset_later_cnt: got %0d, required %0d", if_a.cycle_cnt, cnt_a % 16);
    end
    sb_drain(1'b0, "held_reset_later_step");
  endtask

  task automatic test_run_div4();
    int c;
    int d;
    tick(1);
    c = cyc;
    d = c + 43;
    if_b.run_in = 1'b1;
    for (int t = c + 6; t <= d + 2; t += 4) begin
      exp_b.push_back(mk_ev(t, cnt_b));
      cnt_b++;
    end
    tick(20);
    checks++;
    if (if_b.running !== 1'b1) begin failures++; $display("FAIL run_div4_running: got %b, required 1", if_b.running); end
    tick(d - cyc);
    if_b.run_in = 1'b0;
    tick(2);
    checks++;
    if (if_b.running !== 1'b1) begin failures++; $display("FAIL run_div4_stop_early: got %b, required 1", if_b.running); end
    tick(1);
    checks++;
    if (if_b.running !== 1'b0) begin failures++; $display("FAIL run_div4_stop: got %b, required 0", if_b.running); end
    tick(4);
    checks++;
    if (if_b.cycle_cnt !== 32'(cnt_b)) begin
      failures++; $display("FAIL run_div4_cnt: got %0d, required %0d", if_b.cycle_cnt, cnt_b);
    end
    sb_drain(1'b1, "run_div4");
  endtask

  task automatic test_wrap();
    int c;
    apply_reset();
    tick(2);
    c = cyc;
    if_a.run_in = 1'b1;
    for (int t = c + 3; t <= c + 19; t++) begin
      exp_a.push_back(mk_ev(t, cnt_a % 16));
      cnt_a++;
    end
    tick(17);
    if_a.run_in = 1'b0;
    tick(1);
    checks++;
    if (if_a.cycle_cnt !== 4'd15) begin failures++; $display("FAIL wrap_15: got %0d, required 15", if_a.cycle_cnt); end
    tick(1);
    checks++;
    if (if_a.cycle_cnt !== 4'd0) begin failures++; $display("FAIL wrap_0: got %0d, required 0", if_a.cycle_cnt); end
    tick(1);
    checks++;
    if (if_a.cycle_cnt !== 4'd1) begin failures++; $display("FAIL wrap_1: got %0d, required 1", if_a.cycle_cnt); end
    tick(3);
    checks++;
    if (if_a.running !== 1'b0 || if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL wrap_end: running=%b cnt=%0d, required 0/%0d", if_a.running, if_a.cycle_cnt, cnt_a % 16);
    end
    sb_drain(1'b0, "wrap");
  endtask

  task automatic test_run_step_same_edge();
    int c;
    tick(1);
    c = cyc;
    if_a.run_in  = 1'b1;
    if_a.step_in = 1'b1;
    for (int t = c + 3; t <= c + 8; t++) begin
      exp_a.push_back(mk_ev(t, cnt_a % 16));
      cnt_a++;
    end
    tick(3);
    checks++;
    if (if_a.running !== 1'b1) begin failures++; $display("FAIL run_step_running: got %b, required 1", if_a.running); end
    tick(3);
    if_a.run_in = 1'b0;
    tick(4);
    if_a.step_in = 1'b0;
    tick(2);
    checks++;
    if (if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL run_step_cnt: got %0d, required %0d", if_a.cycle_cnt, cnt_a % 16);
    end
    sb_drain(1'b0, "run_step_same_edge");
  endtask

  task automatic test_halt_with_step();
    tick(1);
    if_a.step_in = 1'b1;
    tick(2);
    if_a.halt = 1'b1;
    tick(1);
    if_a.halt = 1'b0;
    checks++;
    if (if_a.halted !== 1'b1) begin failures++; $display("FAIL halt_step_halted: got %b, required 1", if_a.halted); end
    tick(3);
    if_a.step_in = 1'b0;
    checks++;
    if (if_a.halted !== 1'b1 || if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL halt_step_hold: halted=%b cnt=%0d, required 1/%0d", if_a.halted, if_a.cycle_cnt, cnt_a % 16);
    end
    sb_drain(1'b0, "halt_with_step");
    apply_reset();
    checks++;
    if (if_a.halted !== 1'b0) begin failures++; $display("FAIL halt_step_reset: got %b, required 0", if_a.halted); end
  endtask

  task automatic test_halt_in_run();
    int c;
    tick(1);
    c = cyc;
    if_a.run_in = 1'b1;
    for (int t = c + 3; t <= c + 7; t++) begin
      exp_a.push_back(mk_ev(t, cnt_a % 16));
      cnt_a++;
    end
    tick(8);
    if_a.halt = 1'b1;
    tick(1);
    if_a.halt = 1'b0;
    checks++;
    if (if_a.halted !== 1'b1 || if_a.running !== 1'b0) begin
      failures++; $display("FAIL halt_run_state: halted=%b running=%b, required 1/0", if_a.halted, if_a.running);
    end
    for (int i = 0; i < 6; i++) begin
      if_a.run_in  = ~if_a.run_in;
      if_a.step_in = ~if_a.step_in;
      tick(3);
    end
    checks++;
    if (if_a.halted !== 1'b1 || if_a.cycle_cnt !== 4'(cnt_a % 16)) begin
      failures++; $display("FAIL halt_run_sticky: halted=%b cnt=%0d, required 1/%0d", if_a.halted, if_a.cycle_cnt, cnt_a % 16);
    end
    sb_drain(1'b0, "halt_in_run");
    if_a.run_in  = 1'b0;
    if_a.step_in = 1'b0;
    rst = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    #1;
    checks++;
    if (if_a.halted !== 1'b0 || if_a.cycle_cnt !== 4'd0) begin
      failures++; $display("FAIL halt_run_async_reset: halted=%b cnt=%0d, required 0/0", if_a.halted, if_a.cycle_cnt);
    end
    tick(2);
    rst = 1'b0;
    tick(4);
    sb_drain(1'b0, "after_final_reset");
  endtask

  initial begin
    test_reset();
    test_step();
    test_step_held_reset();
    test_run_div4();
    test_wrap();
    test_run_step_same_edge();
    test_halt_with_step();
    test_halt_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
